regfile_wb_arbiter: RTL and testbench

- Shares the single integer register-file write port between three writeback sources: ALU (src0), load/store unit (src1) and multiply/divide unit (src2).
- Holds a destination scoreboard for long-latency instructions and reports RAW/WAW hazards to the issue stage.
- Drives the register file write port (wb_en_int, rd_index, wb_data) from registered outputs.
- Sits between the execute/memory stages and the integer register file.

---
 rtl/regfile_wb_arbiter_if.sv | 57 +++++
 rtl/regfile_wb_arbiter.sv | 126 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback/issue bundle between the execute/memory stages, the issue stage and the
// integer register-file write port.
interface regfile_wb_arbiter_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int IDX = $clog2(NREG);

    logic            stall_CPU;

    logic            alu_valid;
    logic [IDX-1:0]  alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;

    logic            lsu_valid;
    logic [IDX-1:0]  lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            lsu_ready;

    logic            mdu_valid;
    logic [IDX-1:0]  mdu_rd;
    logic [XLEN-1:0] mdu_data;
    logic            mdu_ready;

    logic            iss_valid;
    logic [IDX-1:0]  iss_rd;
    logic            iss_ready;

    logic [IDX-1:0]  rs1_index;
    logic [IDX-1:0]  rs2_index;
    logic            rs_hazard;

    logic            wb_en_int;
    logic [IDX-1:0]  rd_index;
    logic [XLEN-1:0] wb_data;

    modport master (
        output stall_CPU,
        output alu_valid, alu_rd, alu_data, input alu_ready,
        output lsu_valid, lsu_rd, lsu_data, input lsu_ready,
        output mdu_valid, mdu_rd, mdu_data, input mdu_ready,
        output iss_valid, iss_rd, input iss_ready,
        output rs1_index, rs2_index, input rs_hazard,
        input  wb_en_int, rd_index, wb_data
    );

    modport slave (
        input  stall_CPU,
        input  alu_valid, alu_rd, alu_data, output alu_ready,
        input  lsu_valid, lsu_rd, lsu_data, output lsu_ready,
        input  mdu_valid, mdu_rd, mdu_data, output mdu_ready,
        input  iss_valid, iss_rd, output iss_ready,
        input  rs1_index, rs2_index, output rs_hazard,
        output wb_en_int, rd_index, wb_data
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Three-way writeback arbiter for the integer register-file write port, with
// starvation promotion for LSU/MDU and a pending-destination scoreboard for issue.
module regfile_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int NREG         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int IDX = $clog2(NREG);
    localparam int CW  = $clog2(STARVE_LIMIT + 1);

    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t LIMIT = cnt_t'(STARVE_LIMIT);

    logic            gnt_alu, gnt_lsu, gnt_mdu, gnt_any;
    logic [IDX-1:0]  win_rd;
    logic [XLEN-1:0] win_data;

    cnt_t            lsu_starve_q, lsu_starve_d;
    cnt_t            mdu_starve_q, mdu_starve_d;

    logic [NREG-1:0] busy_q, busy_d;
    logic            iss_accept;

    logic            wb_en_q, wb_en_d;
    logic [IDX-1:0]  rd_q, rd_d;
    logic [XLEN-1:0] data_q, data_d;

    // A starved source jumps to the top; LSU is checked first so it wins a tie.
    always_comb begin
        gnt_alu = 1'b0;
        gnt_lsu = 1'b0;
        gnt_mdu = 1'b0;
        if (!bus.stall_CPU) begin
            if (lsu_starve_q == LIMIT) begin
                if (bus.lsu_valid)      gnt_lsu = 1'b1;
                else if (bus.mdu_valid) gnt_mdu = 1'b1;
                else if (bus.alu_valid) gnt_alu = 1'b1;
            end else if (mdu_starve_q == LIMIT) begin
                if (bus.mdu_valid)      gnt_mdu = 1'b1;
                else if (bus.lsu_valid) gnt_lsu = 1'b1;
                else if (bus.alu_valid) gnt_alu = 1'b1;
            end else begin
                if (bus.alu_valid)      gnt_alu = 1'b1;
                else if (bus.lsu_valid) gnt_lsu = 1'b1;
                else if (bus.mdu_valid) gnt_mdu = 1'b1;
            end
        end
    end

    assign gnt_any = gnt_alu | gnt_lsu | gnt_mdu;

    always_comb begin
        win_rd   = bus.alu_rd;
        win_data = bus.alu_data;
        if (gnt_lsu) begin
            win_rd   = bus.lsu_rd;
            win_data = bus.lsu_data;
        end else if (gnt_mdu) begin
            win_rd   = bus.mdu_rd;
            win_data = bus.mdu_data;
        end
    end

    always_comb begin
        lsu_starve_d = lsu_starve_q;
        mdu_starve_d = mdu_starve_q;
        if (!bus.stall_CPU) begin
            if (gnt_lsu)
                lsu_starve_d = '0;
            else if (bus.lsu_valid && lsu_starve_q != LIMIT)
                lsu_starve_d = lsu_starve_q + cnt_t'(1);
            if (gnt_mdu)
                mdu_starve_d = '0;
            else if (bus.mdu_valid && mdu_starve_q != LIMIT)
                mdu_starve_d = mdu_starve_q + cnt_t'(1);
        end
    end

    assign iss_accept = bus.iss_valid && !busy_q[bus.iss_rd] && !bus.stall_CPU;

    // Set is applied after the clears so a same-cycle issue keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (gnt_lsu) busy_d[bus.lsu_rd] = 1'b0;
        if (gnt_mdu) busy_d[bus.mdu_rd] = 1'b0;
        if (iss_accept && bus.iss_rd != '0) busy_d[bus.iss_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        wb_en_d = gnt_any && (win_rd != '0);
        rd_d    = gnt_any ? win_rd   : rd_q;
        data_d  = gnt_any ? win_data : data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lsu_starve_q <= '0;
            mdu_starve_q <= '0;
            busy_q       <= '0;
            wb_en_q      <= 1'b0;
            rd_q         <= '0;
            data_q       <= '0;
        end else begin
            lsu_starve_q <= lsu_starve_d;
            mdu_starve_q <= mdu_starve_d;
            busy_q       <= busy_d;
            wb_en_q      <= wb_en_d;
            rd_q         <= rd_d;
            data_q       <= data_d;
        end
    end

    assign bus.alu_ready = gnt_alu;
    assign bus.lsu_ready = gnt_lsu;
    assign bus.mdu_ready = gnt_mdu;
    assign bus.iss_ready = !busy_q[bus.iss_rd] && !bus.stall_CPU;
    assign bus.rs_hazard = busy_q[bus.rs1_index] | busy_q[bus.rs2_index];
    assign bus.wb_en_int = wb_en_q;
    assign bus.rd_index  = rd_q;
    assign bus.wb_data   = data_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes are queued at grant time
// and matched against the registered write port one cycle later.
module tb_regfile_wb_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   cyc;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    regfile_wb_arbiter_if #(.XLEN(32), .NREG(32)) bus ();

    regfile_wb_arbiter #(.XLEN(32), .NREG(32), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write-port monitor: the queue front names the cycle its write must appear in.
    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                chk("wb_en_int", {63'd0, bus.wb_en_int}, 64'd1);
                chk("rd_index", {59'd0, bus.rd_index}, {59'd0, exp_q[0].rd});
                chk("wb_data", {32'd0, bus.wb_data}, {32'd0, exp_q[0].data});
                void'(exp_q.pop_front());
            end else begin
                chk("wb_idle", {63'd0, bus.wb_en_int}, 64'd0);
            end
        end
    end

    task automatic clear_inputs();
        bus.stall_CPU = 0;
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
        bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
        bus.mdu_valid = 0; bus.mdu_rd = 0; bus.mdu_data = 0;
        bus.iss_valid = 0; bus.iss_rd = 0;
        bus.rs1_index = 0; bus.rs2_index = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        exp_q.delete();
        @(posedge clk);
        #3 rst = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic grants(input string tag, input logic ea, input logic el, input logic em);
        @(negedge clk);
        chk({tag, ".alu_ready"}, {63'd0, bus.alu_ready}, {63'd0, ea});
        chk({tag, ".lsu_ready"}, {63'd0, bus.lsu_ready}, {63'd0, el});
        chk({tag, ".mdu_ready"}, {63'd0, bus.mdu_ready}, {63'd0, em});
        if (ea && bus.alu_rd != 0) exp_q.push_back('{cyc + 1, bus.alu_rd, bus.alu_data});
        if (el && bus.lsu_rd != 0) exp_q.push_back('{cyc + 1, bus.lsu_rd, bus.lsu_data});
        if (em && bus.mdu_rd != 0) exp_q.push_back('{cyc + 1, bus.mdu_rd, bus.mdu_data});
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1;
        clear_inputs();
        @(posedge clk);
        #1;
        chk("rst.wb_en_int", {63'd0, bus.wb_en_int}, 64'd0);
        chk("rst.rd_index", {59'd0, bus.rd_index}, 64'd0);
        chk("rst.wb_data", {32'd0, bus.wb_data}, 64'd0);
        chk("rst.rs_hazard", {63'd0, bus.rs_hazard}, 64'd0);
        #2 rst = 0;
        next();

        // Lone ALU write
        bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_data = 32'h1234;
        grants("alu_lone", 1, 0, 0);
        next();
        bus.alu_valid = 0;
        grants("alu_lone_after", 0, 0, 0);
        next();

        // Starvation promotion with all three sources requesting
        do_reset();
        bus.alu_valid = 1; bus.alu_rd = 1;
        bus.lsu_valid = 1; bus.lsu_rd = 2; bus.lsu_data = 32'hB000;
        bus.mdu_valid = 1; bus.mdu_rd = 3; bus.mdu_data = 32'hC000;
        for (int i = 0; i < 4; i++) begin
            bus.alu_data = 32'hA000 + i;
            grants("starve_alu", 1, 0, 0);
            next();
        end
        grants("starve_lsu", 0, 1, 0);
        next();
        bus.lsu_data = 32'hB001;
        grants("starve_mdu", 0, 0, 1);
        next();
        bus.mdu_data = 32'hC001;
        bus.alu_data = 32'hA010;
        grants("starve_back_alu", 1, 0, 0);
        next();

        // Scoreboard set, hazard, and clear by LSU writeback
        do_reset();
        bus.iss_valid = 1; bus.iss_rd = 7;
        @(negedge clk);
        chk("iss7.iss_ready", {63'd0, bus.iss_ready}, 64'd1);
        next();
        bus.iss_valid = 0; bus.rs1_index = 7;
        grants("sb_idle", 0, 0, 0);
        chk("sb.rs_hazard_set", {63'd0, bus.rs_hazard}, 64'd1);
        chk("sb.iss_ready_waw", {63'd0, bus.iss_ready}, 64'd0);
        next();
        bus.lsu_valid = 1; bus.lsu_rd = 7; bus.lsu_data = 32'h77;
        grants("sb_lsu7", 0, 1, 0);
        chk("sb.no_forward", {63'd0, bus.rs_hazard}, 64'd1);
        next();
        bus.lsu_valid = 0;
        grants("sb_after", 0, 0, 0);
        chk("sb.rs_hazard_clr", {63'd0, bus.rs_hazard}, 64'd0);
        chk("sb.iss_ready_clr", {63'd0, bus.iss_ready}, 64'd1);
        next();

        // Same-cycle issue and MDU clear of rd=9: set wins
        bus.rs1_index = 0;
        bus.iss_valid = 1; bus.iss_rd = 9;
        bus.mdu_valid = 1; bus.mdu_rd = 9; bus.mdu_data = 32'h99;
        grants("setclr_mdu9", 0, 0, 1);
        chk("setclr.iss_ready", {63'd0, bus.iss_ready}, 64'd1);
        next();
        bus.iss_valid = 0; bus.mdu_valid = 0; bus.rs2_index = 9;
        grants("setclr_after", 0, 0, 0);
        chk("setclr.rs_hazard", {63'd0, bus.rs_hazard}, 64'd1);
        next();

        // Stall holds counters and blocks grants
        do_reset();
        bus.alu_valid = 1; bus.alu_rd = 1; bus.alu_data = 32'hD0;
        bus.lsu_valid = 1; bus.lsu_rd = 2; bus.lsu_data = 32'hD1;
        bus.mdu_valid = 1; bus.mdu_rd = 3; bus.mdu_data = 32'hD2;
        grants("pre_stall0", 1, 0, 0);
        next();
        grants("pre_stall1", 1, 0, 0);
        next();
        bus.stall_CPU = 1;
        for (int i = 0; i < 3; i++) begin
            grants("stall", 0, 0, 0);
            chk("stall.iss_ready", {63'd0, bus.iss_ready}, 64'd0);
            next();
        end
        bus.stall_CPU = 0;
        grants("release0", 1, 0, 0);
        next();
        grants("release1", 1, 0, 0);
        next();
        grants("release_lsu", 0, 1, 0);
        next();
        grants("release_mdu", 0, 0, 1);
        next();

        // rd=0 write suppressed; reset drops a pending write and clears busy bits
        do_reset();
        bus.alu_valid = 1; bus.alu_rd = 0; bus.alu_data = 32'hFFFF;
        grants("alu_rd0", 1, 0, 0);
        next();
        bus.alu_rd = 12; bus.alu_data = 32'hC;
        bus.iss_valid = 1; bus.iss_rd = 4;
        grants("alu_rd12", 1, 0, 0);
        next();
        chk("pre_rst.wb_en_int", {63'd0, bus.wb_en_int}, 64'd1);
        chk("pre_rst.rd_index", {59'd0, bus.rd_index}, 64'd12);
        bus.alu_valid = 0; bus.iss_valid = 0; bus.rs1_index = 4;
        #1;
        chk("pre_rst.rs_hazard", {63'd0, bus.rs_hazard}, 64'd1);
        rst = 1;
        #1;
        chk("mid_rst.wb_en_int", {63'd0, bus.wb_en_int}, 64'd0);
        chk("mid_rst.rd_index", {59'd0, bus.rd_index}, 64'd0);
        chk("mid_rst.wb_data", {32'd0, bus.wb_data}, 64'd0);
        chk("mid_rst.rs_hazard", {63'd0, bus.rs_hazard}, 64'd0);
        do_reset();
        grants("post_rst", 0, 0, 0);
        next();

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
